// File: rtl/alu_exec_stage.sv
// alu_exec_stage: R-type execute stage with a 2-entry (output + skid) writeback buffer
module alu_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_in,
    input  logic                  regwrite,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_we,
    output logic [CNT_W-1:0]      illegal_cnt
);
    logic                  or_valid_q, or_valid_d, or_we_q, or_we_d;
    logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
    logic [REG_ADDR_W-1:0] or_rd_q, or_rd_d;
    logic                  sk_valid_q, sk_valid_d, sk_we_q, sk_we_d;
    logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
    logic [REG_ADDR_W-1:0] sk_rd_q, sk_rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res;
    logic                  legal, new_we, accept, drain;

    assign in_ready    = !sk_valid_q;
    assign accept      = in_valid && in_ready;
    assign drain       = or_valid_q && out_ready;
    assign new_we      = regwrite && legal && (rd != '0);
    assign out_valid   = or_valid_q;
    assign wb_data     = or_data_q;
    assign wb_rd       = or_rd_q;
    assign wb_we       = or_valid_q && or_we_q;
    assign illegal_cnt = cnt_q;

    // Decode the opcode and compute the result; unknown codes give zero
    always_comb begin
        legal = 1'b1;
        res   = '0;
        case (alu_in)
            4'b0000: res = op_a + op_b;
            4'b0001: res = op_a - op_b;
            4'b0010: res = op_a << op_b[4:0];
            4'b0011: res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0100: res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
            4'b0101: res = op_a ^ op_b;
            4'b0110: res = op_a >> op_b[4:0];
            4'b0111: res = $signed(op_a) >>> op_b[4:0];
            4'b1000: res = op_a | op_b;
            4'b1001: res = op_a & op_b;
            default: legal = 1'b0;
        endcase
    end

    // Buffer next state: skid refills the output register first, flush drops everything
    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_rd_d    = or_rd_q;
        or_we_d    = or_we_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_rd_d    = sk_rd_q;
        sk_we_d    = sk_we_q;
        cnt_d      = cnt_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else begin
            if (accept && !legal && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
            if (!or_valid_q || drain) begin
                if (sk_valid_q) begin
                    or_valid_d = 1'b1;
                    or_data_d  = sk_data_q;
                    or_rd_d    = sk_rd_q;
                    or_we_d    = sk_we_q;
                    sk_valid_d = 1'b0;
                end else begin
                    or_valid_d = accept;
                    if (accept) begin
                        or_data_d = res;
                        or_rd_d   = rd;
                        or_we_d   = new_we;
                    end
                end
            end else if (accept) begin
                sk_valid_d = 1'b1;
                sk_data_d  = res;
                sk_rd_d    = rd;
                sk_we_d    = new_we;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_rd_q    <= '0;
            or_we_q    <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_rd_q    <= '0;
            sk_we_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_rd_q    <= or_rd_d;
            or_we_q    <= or_we_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_rd_q    <= sk_rd_d;
            sk_we_q    <= sk_we_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed checks of the execute stage and its writeback buffer
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, regwrite, out_valid, out_ready, wb_we;
    logic [3:0]  alu_in;
    logic [31:0] op_a, op_b, wb_data;
    logic [4:0]  rd, wb_rd;
    logic [7:0]  illegal_cnt;
    int checks = 0;
    int errors = 0;

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_in(alu_in), .regwrite(regwrite), .op_a(op_a), .op_b(op_b), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_we(wb_we), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic rw);
        in_valid = 1'b1;
        alu_in   = op;
        op_a     = a;
        op_b     = b;
        rd       = r;
        regwrite = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                       input logic exp_we);
        drive(op, a, b, r, 1'b1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_we"}, wb_we, exp_we);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_in = '0; regwrite = 1'b0; op_a = '0; op_b = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        one("add", 4'b0000, 32'h7FFFFFFF, 32'h1, 5'd5, 32'h80000000, 1'b1);
        chk("add_rd", wb_rd, 5);
        one("sub", 4'b0001, 32'h0, 32'h1, 5'd6, 32'hFFFFFFFF, 1'b1);
        one("sll", 4'b0010, 32'h1, 32'h21, 5'd7, 32'h2, 1'b1);
        one("sra", 4'b0111, 32'h80000000, 32'h24, 5'd8, 32'hF8000000, 1'b1);
        one("srl", 4'b0110, 32'h80000000, 32'h24, 5'd8, 32'h08000000, 1'b1);
        one("slt", 4'b0011, 32'hFFFFFFFF, 32'h1, 5'd9, 32'h1, 1'b1);
        one("sltu", 4'b0100, 32'hFFFFFFFF, 32'h1, 5'd9, 32'h0, 1'b1);
        one("xor", 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd10, 32'h0FF00FF0, 1'b1);
        one("or", 4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd11, 32'hFFF0FFF0, 1'b1);
        one("and", 4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd12, 32'hF000F000, 1'b1);
        one("x0", 4'b0000, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);
        one("ill15", 4'b1111, 32'd2, 32'd3, 5'd4, 32'd0, 1'b0);
        chk("ill15_cnt", illegal_cnt, 1);
        one("ill10", 4'b1010, 32'd2, 32'd3, 5'd4, 32'd0, 1'b0);
        chk("ill10_cnt", illegal_cnt, 2);
        tick();
        chk("drained", out_valid, 0);

        out_ready = 1'b0;
        drive(4'b0000, 32'd10, 32'd1, 5'd1, 1'b1);
        tick();
        drive(4'b0000, 32'd20, 32'd1, 5'd2, 1'b1);
        tick();
        chk("fl_full", in_ready, 0);
        drive(4'b1111, 32'd30, 32'd1, 5'd3, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_we", wb_we, 0);
        chk("fl_cnt", illegal_cnt, 2);
        out_ready = 1'b1;
        tick();
        chk("fl_gone", out_valid, 0);

        out_ready = 1'b0;
        drive(4'b0000, 32'd1, 32'd1, 5'd1, 1'b1);
        tick();
        chk("bp_a_ready", in_ready, 1);
        drive(4'b0000, 32'd2, 32'd2, 5'd2, 1'b1);
        tick();
        chk("bp_b_ready", in_ready, 0);
        drive(4'b0000, 32'd3, 32'd3, 5'd3, 1'b1);
        tick();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_data", wb_data, 2);
        chk("bp_hold_rd", wb_rd, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data", wb_data, 4);
        chk("bp_b_rd", wb_rd, 2);
        chk("bp_b_ready2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_valid", out_valid, 1);
        chk("bp_c_data", wb_data, 6);
        chk("bp_c_rd", wb_rd, 3);
        tick();
        chk("bp_empty", out_valid, 0);

        drive(4'b1111, 32'd0, 32'd0, 5'd1, 1'b1);
        for (int i = 0; i < 256; i++) tick();
        in_valid = 1'b0;
        chk("sat_cnt", illegal_cnt, 8'hFF);
        chk("sat_we", wb_we, 0);
        tick();

        out_ready = 1'b0;
        drive(4'b0000, 32'd7, 32'd7, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_we", wb_we, 0);
        chk("ar_cnt", illegal_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        one("ar_add", 4'b0000, 32'd2, 32'd3, 5'd9, 32'd5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU-control decoder.
- Consumes the 4-bit ALU operation code and regwrite flag together with two register operands and a destination index.
- Computes the R-type result and holds it in a registered 2-entry output buffer (output register plus skid register) with valid/ready handshakes on both sides.
- Feeds the register-file writeback port.

Parameters:
- DATA_WIDTH, 32, operand/result width; shift amount is always op_b[4:0].
- REG_ADDR_W, 5, destination register index width.
- CNT_W, 8, width of the saturating illegal-operation counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept this cycle.
- alu_in  input  4  operation code from ALU control.
- regwrite  input  1  writeback request from ALU control.
- op_a  input  DATA_WIDTH  rs1 value.
- op_b  input  DATA_WIDTH  rs2 value.
- rd  input  REG_ADDR_W  destination register index.
- out_valid  output  1  writeback entry valid.
- out_ready  input  1  register file consumes the entry.
- wb_data  output  DATA_WIDTH  result.
- wb_rd  output  REG_ADDR_W  destination index.
- wb_we  output  1  register-file write enable.
- illegal_cnt  output  CNT_W  count of accepted illegal codes.

Behaviour:
- Reset (async assert, sync release): out_valid=0, wb_data=0, wb_rd=0, wb_we=0, illegal_cnt=0, skid empty, in_ready=1.
- Opcode map, all arithmetic modulo 2^DATA_WIDTH:
  - 0000 ADD, 0001 SUB.
  - 0010 SLL a<<b[4:0].
  - 0011 SLT signed a<b -> 1/0.
  - 0100 SLTU unsigned a<b -> 1/0.
  - 0101 XOR.
  - 0110 SRL logical.
  - 0111 SRA arithmetic, sign-filled.
  - 1000 OR, 1001 AND.
- Any other code, including 1111, is illegal: result=0, entry we=0, illegal_cnt+1 saturating at all-ones. Entry still flows through as a bubble with out_valid=1.
- Entry write enable = regwrite AND legal AND (rd!=0). Writes to x0 are always suppressed; result is still computed and presented.
- Accept: in_valid && in_ready. Result is computed combinationally and captured at that edge. Latency is 1 cycle: the entry appears on the outputs the cycle after acceptance when the output register is empty or draining.
- Output register (OR) and skid register (SK) rules:
  - in_ready = !SK.valid (registered; no combinational path from out_ready).
  - OR drains when out_valid && out_ready.
  - On accept: if OR is empty or draining, the new entry loads OR (with SK empty). Otherwise it loads SK.
  - When OR drains and SK is valid, SK moves to OR and SK empties. A simultaneous accept is impossible because in_ready=0.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- Full: both entries valid -> in_ready=0. Back-to-back throughput is 1 op/cycle when out_ready=1.
- out_ready may drop at any time; outputs hold stable while out_valid && !out_ready.
- flush=1: both entries are invalidated at the edge and in_ready=1 the next cycle. Flush wins over a same-cycle accept (the accepted op is discarded and illegal_cnt is not incremented). illegal_cnt itself is not cleared by flush.
- Reset mid-operation: all entries are discarded immediately, with no partial writeback (wb_we forced 0 while rst_n=0).

Test Plan:
- ADD/SUB: a=0x7FFFFFFF, b=1, alu_in=0000, rd=5, regwrite=1 -> next cycle out_valid=1, wb_data=0x80000000, wb_rd=5, wb_we=1. Same with 0001, a=0, b=1 -> wb_data=0xFFFFFFFF.
- Shifts/compares:
  - SRA a=0x80000000, b=0x24 -> 0xF8000000 (shamt 4).
  - SRL same operands -> 0x08000000.
  - SLT a=0xFFFFFFFF, b=1 -> 1.
  - SLTU same operands -> 0.
- x0 and illegal:
  - rd=0, ADD -> wb_we=0.
  - alu_in=1111 -> wb_data=0, wb_we=0, illegal_cnt=1.
  - 256 illegal ops with CNT_W=8 -> illegal_cnt stays 0xFF.
- Backpressure: hold out_ready=0 and issue 3 back-to-back ops -> first two accepted, in_ready=0 on the third. Release out_ready -> results exit in order A, B, then C is accepted.
- Flush: flush asserted with in_valid=1 and 2 entries buffered -> next cycle out_valid=0, in_ready=1, flushed op never appears.
- Async reset: drop rst_n mid-stream between clock edges -> out_valid=0 and wb_we=0 immediately. After release, a new ADD 2+3 yields wb_data=5.
